// File: rtl/param_sync_fifo_if.sv
// Handshake/data bundle for param_sync_fifo: the producer/consumer side drives
// the master modport, the FIFO implements the slave modport.
interface param_sync_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  clear;
  logic [DATA_WIDTH-1:0] din;
  logic                  shift_in;
  logic                  shift_out;
  logic [DATA_WIDTH-1:0] dout;
  logic                  valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, din, shift_in, shift_out,
    input  dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clear, din, shift_in, shift_out,
    output dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock circular-buffer FIFO with fill count, programmable almost flags,
// synchronous clear and selectable read latency (0 = bypass-capable head, 1 = registered).
module param_sync_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 1,
  parameter int AF_THRESH    = 14,
  parameter int AE_THRESH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  param_sync_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if ((READ_LATENCY != 0) && (READ_LATENCY != 1)) begin : g_bad_lat
    $error("param_sync_fifo: READ_LATENCY must be 0 or 1");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH) || (AE_THRESH < 0) || (AE_THRESH > DEPTH - 1))
  begin : g_bad_thresh
    $error("param_sync_fifo: almost-full/almost-empty threshold out of range");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q, count_q;
  logic [PW-1:0]         wr_ptr_d, rd_ptr_d, count_d;
  logic                  full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic                  si, so, bypass, rd_acc, wr_acc;

  // clear wins over any request in the same cycle, so it simply masks them.
  assign si     = bus.shift_in  & ~bus.clear;
  assign so     = bus.shift_out & ~bus.clear;
  assign bypass = (READ_LATENCY == 0) && si && so && empty_q;
  assign rd_acc = so && !empty_q;
  assign wr_acc = si && (!full_q || rd_acc) && !bypass;

  assign wr_ptr_d = wr_ptr_q + PW'(wr_acc);
  assign rd_ptr_d = rd_ptr_q + PW'(rd_acc);
  assign count_d  = count_q + PW'(wr_acc) - PW'(rd_acc);

  // NOTE: every register below uses <= so all state updates see the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
      empty_q  <= (wr_ptr_d == rd_ptr_d);
      af_q     <= (count_d >= PW'(AF_THRESH));
      ae_q     <= (count_d <= PW'(AE_THRESH));
      ovf_q    <= si && !wr_acc && !bypass;
      unf_q    <= so && !rd_acc && !bypass;
    end
  end

  // NOTE: storage has no reset; pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q[AW-1:0]] <= bus.din;
  end

  if (READ_LATENCY == 0) begin : g_lat0
    assign bus.dout  = bypass ? bus.din : mem[rd_ptr_q[AW-1:0]];
    assign bus.valid = rd_acc || bypass;
  end else begin : g_lat1
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else if (bus.clear) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr_q[AW-1:0]];
      end
    end

    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
  end

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a registered-read instance (u_fifo1) for the
// main sequence plus a combinational-read instance (u_fifo0) for the bypass path.
module tb_param_sync_fifo;
  localparam int DW = 32;
  localparam int DP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) a ();
  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) b ();

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .READ_LATENCY(1), .AF_THRESH(14), .AE_THRESH(2))
    u_fifo1 (.clk(clk), .rst(rst), .bus(a.slave));
  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .READ_LATENCY(0), .AF_THRESH(14), .AE_THRESH(2))
    u_fifo0 (.clk(clk), .rst(rst), .bus(b.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of requests on instance a; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic si, input logic so, input logic [DW-1:0] d);
    a.shift_in  = si;
    a.shift_out = so;
    a.din       = d;
    @(posedge clk);
    #1;
    a.shift_in  = 1'b0;
    a.shift_out = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, a.count, 0);
    check({tag, "_empty"}, a.empty, 1);
    check({tag, "_full"}, a.full, 0);
    check({tag, "_ae"}, a.almost_empty, 1);
    check({tag, "_af"}, a.almost_full, 0);
    check({tag, "_valid"}, a.valid, 0);
    check({tag, "_ovf"}, a.overflow, 0);
    check({tag, "_unf"}, a.underflow, 0);
    check({tag, "_dout"}, a.dout, 0);
  endtask

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_d;
    logic          si, so, rd, wr;

    a.clear = 1'b0; a.din = '0; a.shift_in = 1'b0; a.shift_out = 1'b0;
    b.clear = 1'b0; b.din = '0; b.shift_in = 1'b0; b.shift_out = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // Fill with 0..15, watching almost flags at their thresholds.
    for (int i = 0; i < DP; i++) begin
      cyc(1'b1, 1'b0, DW'(i));
      if (i == 1)  check("ae_at2", a.almost_empty, 1);
      if (i == 2)  check("ae_at3", a.almost_empty, 0);
      if (i == 12) check("af_at13", a.almost_full, 0);
      if (i == 13) check("af_at14", a.almost_full, 1);
    end
    check("fill_count", a.count, 16);
    check("fill_full", a.full, 1);
    check("fill_empty", a.empty, 0);

    // Write at full without read is rejected for one cycle.
    cyc(1'b1, 1'b0, 32'hDEAD);
    check("ovf_pulse", a.overflow, 1);
    check("ovf_count", a.count, 16);
    cyc(1'b0, 1'b0, '0);
    check("ovf_clear", a.overflow, 0);

    // Simultaneous read+write at full: head 0 leaves, 0xAA joins at the tail.
    cyc(1'b1, 1'b1, 32'hAA);
    check("rw_full_ovf", a.overflow, 0);
    check("rw_full_count", a.count, 16);
    check("rw_full_valid", a.valid, 1);
    check("rw_full_dout", a.dout, 0);

    for (int i = 1; i <= DP; i++) begin
      cyc(1'b0, 1'b1, '0);
      check("drain_dout", a.dout, (i == DP) ? 32'hAA : 32'(i));
      check("drain_valid", a.valid, 1);
    end
    check("drain_empty", a.empty, 1);
    check("drain_count", a.count, 0);
    cyc(1'b0, 1'b0, '0);
    check("hold_valid", a.valid, 0);
    check("hold_dout", a.dout, 32'hAA);

    // Underflow at empty; with registered read a concurrent write still lands.
    cyc(1'b0, 1'b1, '0);
    check("unf_pulse", a.underflow, 1);
    check("unf_valid", a.valid, 0);
    cyc(1'b1, 1'b1, 32'h77);
    check("unf_rw_pulse", a.underflow, 1);
    check("unf_rw_count", a.count, 1);
    cyc(1'b0, 1'b1, '0);
    check("unf_rw_dout", a.dout, 32'h77);
    check("unf_rw_valid", a.valid, 1);
    check("unf_rw_unf", a.underflow, 0);

    // Combinational-read instance: bypass at empty, then same-cycle head read.
    b.din = 32'h55; b.shift_in = 1'b1; b.shift_out = 1'b1;
    #1;
    check("byp_dout", b.dout, 32'h55);
    check("byp_valid", b.valid, 1);
    @(posedge clk);
    #1;
    b.shift_in = 1'b0; b.shift_out = 1'b0;
    check("byp_count", b.count, 0);
    check("byp_unf", b.underflow, 0);
    check("byp_ovf", b.overflow, 0);
    check("byp_empty", b.empty, 1);
    b.din = 32'h11; b.shift_in = 1'b1;
    @(posedge clk);
    #1 b.din = 32'h22;
    @(posedge clk);
    #1 b.shift_in = 1'b0; b.shift_out = 1'b1;
    #1;
    check("lat0_dout", b.dout, 32'h11);
    check("lat0_valid", b.valid, 1);
    @(posedge clk);
    #1 b.shift_out = 1'b0;
    #1;
    check("lat0_next_dout", b.dout, 32'h22);
    check("lat0_idle_valid", b.valid, 0);
    check("lat0_count", b.count, 1);

    // Random mixed traffic against a queue model; pointers are already past one wrap.
    q.delete();
    for (int n = 0; n < 40; n++) begin
      si    = ($urandom_range(2, 0) != 0);
      so    = $urandom_range(1, 0) != 0;
      exp_d = $urandom;
      rd    = so && (q.size() > 0);
      wr    = si && ((q.size() < DP) || rd);
      cyc(si, so, exp_d);
      check("rnd_valid", a.valid, rd);
      if (rd) check("rnd_dout", a.dout, q.pop_front());
      if (wr) q.push_back(exp_d);
      check("rnd_count", a.count, q.size());
      check("rnd_ovf", a.overflow, si && !wr);
      check("rnd_unf", a.underflow, so && !rd);
    end

    // Synchronous clear mid-burst overrides concurrent requests.
    cyc(1'b1, 1'b0, 32'h1);
    cyc(1'b1, 1'b0, 32'h2);
    a.clear = 1'b1;
    cyc(1'b1, 1'b1, 32'h3);
    a.clear = 1'b0;
    check_reset_state("clear");
    cyc(1'b1, 1'b0, 32'hC0DE);
    cyc(1'b0, 1'b1, '0);
    check("post_clear_dout", a.dout, 32'hC0DE);

    // Asynchronous reset between edges takes effect immediately.
    cyc(1'b1, 1'b0, 32'h9);
    cyc(1'b1, 1'b0, 32'hA);
    #2 rst = 1'b1;
    #1;
    check_reset_state("arst");
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, '0);
    check_reset_state("arst_rel");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
